// File: rtl/memory_pkg.sv
// Shared encodings for the memory game turn controller and its board cells.
package memory_pkg;

  localparam logic [3:0] CELL_HIDDEN   = 4'b0000;
  localparam logic [3:0] CELL_CURSOR   = 4'b1111;
  localparam logic [3:0] CELL_MATCH_P0 = 4'b1001;
  localparam logic [3:0] CELL_MATCH_P1 = 4'b1010;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P0   = 2'b01;
  localparam logic [1:0] WIN_P1   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  typedef enum logic [2:0] {
    ST_PICK1,
    ST_PICK2,
    ST_COMPARE,
    ST_SHOW,
    ST_RESOLVE,
    ST_OVER
  } turn_state_e;

  // Final result from the two pair counts.
  function automatic logic [1:0] winner_of(input logic [3:0] s0, input logic [3:0] s1);
    logic [1:0] w;
    if (s0 > s1)      w = WIN_P0;
    else if (s1 > s0) w = WIN_P1;
    else              w = WIN_TIE;
    return w;
  endfunction

endpackage

// File: rtl/sec_timer.sv
// Loadable 4-bit seconds down-counter; zero_c flags the tick that reaches zero.
module sec_timer #(
  parameter logic [3:0] RESET_VAL = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic [3:0] count,
  output logic       zero_c
);

  assign zero_c = en && (count == 4'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     count <= RESET_VAL;
    else if (load)                count <= load_val;
    else if (en && count != 4'd0) count <= count - 4'd1;
  end

endmodule

// File: rtl/memory_turn_ctrl.sv
// Turn controller for the two-player pairs game: cursor, picks, compare,
// match/hide commands, scoring, per-turn countdown and game-over detection.
module memory_turn_ctrl
  import memory_pkg::*;
#(
  parameter int unsigned NCELLS    = 16,
  parameter int unsigned TURN_SECS = 15,
  parameter int unsigned SHOW_SECS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_next,
  input  logic                  btn_sel,
  input  logic                  sec_tick,
  input  logic [4*NCELLS-1:0]   cell_label,
  input  logic [4*NCELLS-1:0]   cell_state,
  output logic [NCELLS-1:0]     cursor_oh,
  output logic [NCELLS-1:0]     sel_oh,
  output logic [NCELLS-1:0]     match_oh,
  output logic [NCELLS-1:0]     hide_oh,
  output logic                  player,
  output logic [3:0]            score0,
  output logic [3:0]            score1,
  output logic [3:0]            secs_left,
  output logic                  game_over,
  output logic [1:0]            winner
);

  localparam int unsigned       IDXW     = $clog2(NCELLS);
  localparam logic [IDXW-1:0]   LAST_IDX = IDXW'(NCELLS - 1);
  localparam logic [3:0]        HALF     = 4'(NCELLS / 2);
  localparam logic [3:0]        TURN_VAL = 4'(TURN_SECS);
  localparam logic [3:0]        SHOW_VAL = 4'(SHOW_SECS);
  localparam logic [NCELLS-1:0] ONE      = {{(NCELLS-1){1'b0}}, 1'b1};

  turn_state_e     state;
  logic [IDXW-1:0] idx, idx1, idx2, next_idx_c;
  logic [3:0]      pairs_found;
  logic [3:0]      cur_cell_c;
  logic            in_pick_c, pick_ok_c, labels_eq_c;
  logic            turn_load_c, turn_en_c, turn_expire_c;
  logic            show_load_c, show_en_c, show_expire_c;
  logic [3:0]      show_left_unused;

  function automatic logic [NCELLS-1:0] onehot(input logic [IDXW-1:0] i);
    return ONE << i;
  endfunction

  // A pick is legal on a face-down card, and never twice on the same card.
  assign cur_cell_c  = cell_state[{idx, 2'b00} +: 4];
  assign in_pick_c   = (state == ST_PICK1) || (state == ST_PICK2);
  assign pick_ok_c   = btn_sel && in_pick_c &&
                       (cur_cell_c == CELL_HIDDEN || cur_cell_c == CELL_CURSOR) &&
                       (state == ST_PICK1 || idx != idx1);
  assign labels_eq_c = cell_label[{idx1, 2'b00} +: 4] == cell_label[{idx2, 2'b00} +: 4];
  assign next_idx_c  = (idx == LAST_IDX) ? '0 : idx + IDXW'(1);

  // Turn clock only runs while a player is picking; a winning select freezes it.
  assign turn_en_c   = sec_tick && in_pick_c && !pick_ok_c;
  assign turn_load_c = (state == ST_RESOLVE) && (pairs_found != HALF);
  assign show_load_c = (state == ST_COMPARE) && !labels_eq_c;
  assign show_en_c   = sec_tick && (state == ST_SHOW);

  sec_timer #(.RESET_VAL(TURN_VAL)) u_turn_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (turn_load_c),
    .load_val (TURN_VAL),
    .en       (turn_en_c),
    .count    (secs_left),
    .zero_c   (turn_expire_c)
  );

  sec_timer #(.RESET_VAL(4'd0)) u_show_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (show_load_c),
    .load_val (SHOW_VAL),
    .en       (show_en_c),
    .count    (show_left_unused),
    .zero_c   (show_expire_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_PICK1;
      idx         <= '0;
      idx1        <= '0;
      idx2        <= '0;
      pairs_found <= '0;
      cursor_oh   <= ONE;
      sel_oh      <= '0;
      match_oh    <= '0;
      hide_oh     <= '0;
      player      <= 1'b0;
      score0      <= '0;
      score1      <= '0;
      game_over   <= 1'b0;
      winner      <= WIN_NONE;
    end else begin
      sel_oh   <= '0;
      match_oh <= '0;
      hide_oh  <= '0;

      if (in_pick_c && btn_next && !btn_sel) begin
        idx       <= next_idx_c;
        cursor_oh <= onehot(next_idx_c);
      end

      case (state)
        ST_PICK1, ST_PICK2: begin
          if (pick_ok_c) begin
            sel_oh <= onehot(idx);
            if (state == ST_PICK1) begin
              idx1  <= idx;
              state <= ST_PICK2;
            end else begin
              idx2  <= idx;
              state <= ST_COMPARE;
            end
          end else if (turn_expire_c) begin
            if (state == ST_PICK2) hide_oh <= onehot(idx1);
            player <= ~player;
            state  <= ST_RESOLVE;
          end
        end
        ST_COMPARE: begin
          if (labels_eq_c) begin
            match_oh <= onehot(idx1) | onehot(idx2);
            if (player) score1 <= score1 + 4'd1;
            else        score0 <= score0 + 4'd1;
            pairs_found <= pairs_found + 4'd1;
            state       <= ST_RESOLVE;
          end else begin
            state <= ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (show_expire_c) begin
            hide_oh <= onehot(idx1) | onehot(idx2);
            player  <= ~player;
            state   <= ST_RESOLVE;
          end
        end
        ST_RESOLVE: begin
          if (pairs_found == HALF) begin
            state     <= ST_OVER;
            game_over <= 1'b1;
            winner    <= winner_of(score0, score1);
          end else begin
            state <= ST_PICK1;
          end
        end
        ST_OVER: state <= ST_OVER;
        default: state <= ST_PICK1;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_turn_ctrl.sv
// Bench for memory_turn_ctrl: board of cells plus a game-rule model, compared every cycle.
module tb_memory_turn_ctrl;

  localparam int N    = 16;
  localparam int TURN = 15;
  localparam int SHOW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           btn_next = 1'b0, btn_sel = 1'b0, sec_tick = 1'b0;
  logic [4*N-1:0] cell_label = '0, cell_state = '0;
  logic [N-1:0]   cursor_oh, sel_oh, match_oh, hide_oh;
  logic           player, game_over;
  logic [3:0]     score0, score1, secs_left;
  logic [1:0]     winner;

  always #5 clk = ~clk;

  memory_turn_ctrl #(.NCELLS(N), .TURN_SECS(TURN), .SHOW_SECS(SHOW)) dut (
    .clk(clk), .rst(rst), .btn_next(btn_next), .btn_sel(btn_sel), .sec_tick(sec_tick),
    .cell_label(cell_label), .cell_state(cell_state), .cursor_oh(cursor_oh),
    .sel_oh(sel_oh), .match_oh(match_oh), .hide_oh(hide_oh), .player(player),
    .score0(score0), .score1(score1), .secs_left(secs_left),
    .game_over(game_over), .winner(winner)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- game model: the rules as a player would describe them ----
  typedef enum {M_PICK1, M_PICK2, M_COMPARE, M_SHOW, M_RESOLVE, M_OVER} phase_t;
  phase_t   ph;
  int       cur, i1, i2, pl, sc0, sc1, secs, showc, pairs, go, win;
  int       lab [N];
  int       rev [N];
  int       owner [N];
  bit       no_reveal = 1'b0;
  bit       chk_en = 1'b0;
  logic [N-1:0] e_sel, e_match, e_hide;

  function automatic logic [N-1:0] bitpos(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [3:0] cell_code(input int c);
    if (owner[c] == 1) return 4'b1001;
    if (owner[c] == 2) return 4'b1010;
    if (rev[c] != 0)   return 4'h5;
    if (c == cur)      return 4'b1111;
    return 4'b0000;
  endfunction

  task automatic model_reset();
    ph = M_PICK1; cur = 0; i1 = 0; i2 = 0; pl = 0; sc0 = 0; sc1 = 0;
    secs = TURN; showc = 0; pairs = 0; go = 0; win = 0;
    e_sel = '0; e_match = '0; e_hide = '0;
    for (int c = 0; c < N; c++) begin rev[c] = 0; owner[c] = 0; end
  endtask

  task automatic drive_board();
    for (int c = 0; c < N; c++) begin
      cell_state[4*c +: 4] = cell_code(c);
      cell_label[4*c +: 4] = 4'(lab[c]);
    end
  endtask

  task automatic model_step(input bit n, input bit s, input bit t);
    phase_t p0;
    bit     ok;
    logic [3:0] st;
    p0 = ph;
    e_sel = '0; e_match = '0; e_hide = '0;
    if (p0 == M_PICK1 || p0 == M_PICK2) begin
      st = cell_code(cur);
      ok = s && (st == 4'b0000 || st == 4'b1111) && (p0 == M_PICK1 || cur != i1);
      if (ok) begin
        e_sel = bitpos(cur);
        if (p0 == M_PICK1) begin i1 = cur; ph = M_PICK2; end
        else begin i2 = cur; ph = M_COMPARE; end
      end else if (t) begin
        if (secs == 1) begin
          secs = 0;
          if (p0 == M_PICK2) e_hide = bitpos(i1);
          pl = 1 - pl;
          ph = M_RESOLVE;
        end else if (secs > 0) secs--;
      end
      if (n && !s) cur = (cur + 1) % N;
    end else if (p0 == M_COMPARE) begin
      if (lab[i1] == lab[i2]) begin
        e_match = bitpos(i1) | bitpos(i2);
        owner[i1] = pl + 1; owner[i2] = pl + 1;
        if (pl == 0) sc0++; else sc1++;
        pairs++;
        ph = M_RESOLVE;
      end else begin
        showc = SHOW;
        ph = M_SHOW;
      end
    end else if (p0 == M_SHOW) begin
      if (t) begin
        showc--;
        if (showc == 0) begin
          e_hide = bitpos(i1) | bitpos(i2);
          pl = 1 - pl;
          ph = M_RESOLVE;
        end
      end
    end else if (p0 == M_RESOLVE) begin
      if (pairs == N / 2) begin
        ph = M_OVER; go = 1;
        win = (sc0 > sc1) ? 1 : (sc1 > sc0) ? 2 : 3;
      end else begin
        secs = TURN;
        ph = M_PICK1;
      end
    end
    // board cells respond to the commands
    for (int c = 0; c < N; c++) begin
      if (e_sel[c] && !no_reveal) rev[c] = 1;
      if (e_hide[c] || e_match[c]) rev[c] = 0;
    end
  endtask

  // ---- per-cycle comparison against the model ----
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("cursor_oh", cursor_oh, bitpos(cur));
      chk("sel_oh", sel_oh, e_sel);
      chk("match_oh", match_oh, e_match);
      chk("hide_oh", hide_oh, e_hide);
      chk("player", player, pl);
      chk("score0", score0, sc0);
      chk("score1", score1, sc1);
      chk("secs_left", secs_left, secs);
      chk("game_over", game_over, go);
      chk("winner", winner, win);
    end
  end

  // ---- stimulus helpers ----
  task automatic cyc(input bit n, input bit s, input bit t);
    @(negedge clk);
    drive_board();
    btn_next = n; btn_sel = s; sec_tick = t;
    model_step(n, s, t);
    @(posedge clk);
    #2;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_cursor"}, cursor_oh, 16'h0001);
    chk({tag, "_pulses"}, {sel_oh, match_oh, hide_oh}, 0);
    chk({tag, "_player"}, player, 0);
    chk({tag, "_scores"}, {score0, score1}, 0);
    chk({tag, "_secs"}, secs_left, 15);
    chk({tag, "_over"}, {game_over, winner}, 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b0; chk_en = 1'b0;
    btn_next = 1'b0; btn_sel = 1'b0; sec_tick = 1'b0;
    model_reset();
    drive_board();
    #1;
    reset_checks(tag);
    @(posedge clk);
    #2;
    rst = 1'b1; chk_en = 1'b1;
  endtask

  task automatic pick(input int target);
    for (int k = 0; k < N && cur != target; k++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
  endtask

  task automatic pair(input int a, input int b);
    pick(a); pick(b);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic shuffle_labels();
    int j, tmp;
    for (int c = 0; c < N; c++) lab[c] = c / 2 + 1;
    for (int c = N - 1; c > 0; c--) begin
      j = int'($urandom_range(0, c));
      tmp = lab[c]; lab[c] = lab[j]; lab[j] = tmp;
    end
  endtask

  initial begin
    int rst_at;
    // game 1 board: label 3 on cells 0/5, labels 2 and 7 on cells 1/2
    lab = '{3, 2, 7, 1, 4, 3, 5, 6, 8, 1, 2, 4, 5, 6, 7, 8};
    do_reset("reset");
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    chk("cursor_after_3_next", cursor_oh, 16'h0008);
    chk("secs_after_next", secs_left, 15);

    do_reset("reset2");
    pick(0);
    chk("sel_cell0", sel_oh, 16'h0001);
    pick(5);
    chk("sel_cell5", sel_oh, 16'h0020);
    cyc(1'b0, 1'b0, 1'b0);
    chk("match_0_5", match_oh, 16'h0021);
    chk("score0_after_match", score0, 1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("match_one_cycle", match_oh, 16'h0000);
    chk("player_keeps_turn", player, 0);

    // mismatch 1/2, revealed for two seconds
    pick(1); pick(2);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("no_hide_after_1_tick", hide_oh, 16'h0000);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("hide_1_2", hide_oh, 16'h0006);
    chk("player_after_miss", player, 1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("secs_reloaded", secs_left, 15);

    // same card twice is ignored, then the turn times out in PICK2
    no_reveal = 1'b1;
    pick(4);
    cyc(1'b0, 1'b1, 1'b0);
    chk("repick_same_ignored", sel_oh, 16'h0000);
    repeat (15) cyc(1'b0, 1'b0, 1'b1);
    chk("timeout_hide_cell4", hide_oh, 16'h0010);
    chk("timeout_secs_zero", secs_left, 0);
    chk("timeout_player", player, 0);
    chk("timeout_scores", {score0, score1}, 8'h10);
    cyc(1'b0, 1'b0, 1'b0);
    no_reveal = 1'b0;

    // a matched card cannot be picked
    pick(0);
    chk("pick_matched_ignored", sel_oh, 16'h0000);
    pick(3);
    chk("pick1_still_open", sel_oh, 16'h0008);

    // full game ending 4-4
    for (int c = 0; c < N; c++) lab[c] = c / 2 + 1;
    do_reset("reset3");
    pair(0, 1); pair(2, 3); pair(4, 5); pair(6, 7);
    chk("p0_four", score0, 4);
    pick(8); pick(10);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("p1_turn", player, 1);
    pair(8, 9); pair(10, 11); pair(12, 13); pair(14, 15);
    chk("tie_game_over", game_over, 1);
    chk("tie_winner", winner, 2'b11);
    chk("tie_scores", {score0, score1}, 8'h44);
    repeat (30) cyc($urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0, $urandom_range(0, 2) == 0);
    chk("over_holds_winner", winner, 2'b11);
    chk("over_holds_cursor", cursor_oh, 16'h8000);
    chk("over_no_pulse", {sel_oh, match_oh, hide_oh}, 0);

    // random play, with one mid-game reset
    for (int g = 0; g < 4; g++) begin
      shuffle_labels();
      no_reveal = (g == 3);
      do_reset("reset_rand");
      rst_at = (g == 1) ? int'($urandom_range(200, 1500)) : -1;
      for (int k = 0; k < 2000; k++) begin
        if (k == rst_at) do_reset("reset_mid");
        cyc($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
      end
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_turn_ctrl.md
# memory_turn_ctrl

Turn controller for the two-player memory (pairs) game board: it owns the cursor, forwards card selections to the cell instances, compares the two revealed labels, and issues per-cell match or hide commands. It also alternates players, keeps scores and a per-turn countdown, and flags game over. The block sits between the debounced button/tick front end and the array of board cells, and drives their cursor, select, match and hide inputs.

## Interface
- NCELLS, 16 — number of board cells; even, 4..16
- TURN_SECS, 15 — seconds allowed per turn, 1..15
- SHOW_SECS, 2 — seconds a mismatched pair stays revealed, 1..15
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- btn_next  in  1  one-cycle pulse: advance cursor
- btn_sel  in  1  one-cycle pulse: pick card under cursor
- sec_tick  in  1  one-cycle pulse, once per second
- cell_label  in  4*NCELLS  hidden label of cell i at bits [4i+3:4i], values 4'h1..4'h8
- cell_state  in  4*NCELLS  current state of cell i, same packing
- cursor_oh  out  NCELLS  one-hot cursor, drives each cell's counter input
- sel_oh  out  NCELLS  one-cycle reveal pulse to one cell
- match_oh  out  NCELLS  one-cycle pair-confirm pulse to the two matched cells
- hide_oh  out  NCELLS  one-cycle return-to-hidden pulse
- player  out  1  current player (0/1)
- score0, score1  out  4 each  pairs won per player
- secs_left  out  4  remaining turn seconds
- game_over  out  1  sticky until reset
- winner  out  2  01 = P0, 10 = P1, 11 = tie, 00 = game in progress

## Operation
- Cell state codes: HIDDEN 4'b0000, CURSOR 4'b1111, MATCH_P0 4'b1001, MATCH_P1 4'b1010; any other value means revealed.
- FSM states: PICK1, PICK2, COMPARE, SHOW, RESOLVE, OVER. Reset enters PICK1.
- Cursor: btn_next moves the cursor to (idx+1) mod NCELLS. It is active only in PICK1 and PICK2.
- A pick is valid only when the cursor cell state is HIDDEN or CURSOR. Invalid picks are ignored with no output change.
- PICK1: a valid pick pulses sel_oh[idx], latches idx1 and goes to PICK2.
- PICK2: a valid pick with idx ≠ idx1 pulses sel_oh[idx], latches idx2 and goes to COMPARE. A pick with idx == idx1 is ignored.
- COMPARE (1 cycle) compares cell_label[idx1] with cell_label[idx2].
  - Equal: pulse match_oh on both cells, increment the current player's score, increment pairs_found, go to RESOLVE. The same player keeps the turn.
  - Unequal: go to SHOW.
- SHOW: count SHOW_SECS sec_ticks, then pulse hide_oh on both cells, toggle player, go to RESOLVE.
- RESOLVE (1 cycle): if pairs_found == NCELLS/2, go to OVER and set winner by score comparison. Otherwise reload secs_left = TURN_SECS and go to PICK1.
- Timeout: in PICK1 or PICK2, sec_tick with secs_left == 1 sets secs_left to 0. If in PICK2, hide_oh[idx1] is pulsed. Then player toggles, go to RESOLVE. No score change.
- OVER: all buttons are ignored; outputs hold.

## Timing
- All outputs are registered.
- sel_oh, match_oh and hide_oh assert in the cycle after the triggering input or state, for exactly one cycle.
- The cursor updates in the cycle after btn_next.
- Reset values: cursor_oh = 1 (cell 0), sel_oh/match_oh/hide_oh = 0, player = 0, score0 = score1 = 0, secs_left = TURN_SECS, game_over = 0, winner = 00.
- Simultaneous events:
  - btn_sel and btn_next together: select wins, cursor holds.
  - btn_sel and the timeout tick together: a valid select wins, and the timer does not decrement that cycle.
  - sec_tick during COMPARE or RESOLVE: ignored by the turn timer.
- Score arithmetic is 4-bit unsigned and cannot overflow, since NCELLS/2 ≤ 8.
- Reset asserted mid-turn: immediate return to reset values. The cells are reset by the same rst.

## Structure
- memory_pkg holds the cell state code constants, the FSM state enum, and the winner encoding constants.
- Sub-module sec_timer: loadable 4-bit down-counter with load value, sec_tick enable and a zero flag. It is used for both the turn countdown and the SHOW delay.

## Test plan
- Reset, then btn_next ×3 -> cursor_oh = 16'h0008, secs_left = 15, player = 0.
- Cells 0 and 5 both have label 4'h3; pick 0, then pick 5 -> sel_oh pulses on bit 0 then bit 5; match_oh = 16'h0021 for one cycle; score0 = 1; player stays 0.
- Labels 4'h2 and 4'h7, pick 1 then 2 -> after 2 sec_ticks, hide_oh = 16'h0006 for one cycle; player = 1; secs_left = 15.
- Pick cell 4, then 15 sec_ticks with no second pick -> hide_oh = 16'h0010; player toggles; scores unchanged.
- Pick the same cell twice, and pick a cell whose state is 4'b1001 -> no sel_oh pulse; FSM stays in PICK2 (respectively PICK1).
- Play all 8 pairs ending at score0 = 4, score1 = 4 -> game_over = 1, winner = 11; further buttons produce no output change. Then assert rst mid-game in a fresh run -> all reset values restored.
